if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipelined MIPS CPU; the producer end of the ID stage's fetch interface.
- Holds the PC and issues requests to a variable-latency instruction memory over a req/ack handshake.
- Drives the IF/ID pipeline register (inst, dpc4) consumed by the decode stage.
- Consumes the decode stage's redirect outputs (pcsource, bpc, jpc, jr target) and its nostall.

---
 rtl/if_fetch_stage.sv | 90 +++++++++
 tb/tb_if_fetch_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the 5-stage pipelined MIPS CPU.
//
// Holds the PC, issues word-aligned fetch requests to a variable-latency
// instruction memory (req/ack), and drives the IF/ID pipeline register
// (inst, dpc4) consumed by decode. Next-PC selection uses decode's redirect
// outputs with delayed-branch semantics: the word written into IF/ID on the
// cycle a redirect is taken is the delay slot and always executes.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   nostall      decode can accept a new instruction this cycle
//   pcsource     next-PC select: 00 pc+4, 01 bpc, 10 da, 11 jpc
//   bpc/jpc/da   branch, jump and jr targets from decode
//   imem_req     fetch request valid (asserted whenever no word is buffered)
//   imem_addr    fetch address, always {pc[31:2], 2'b00}
//   imem_rdata   instruction word, valid with imem_ack
//   imem_ack     memory completes the request this cycle (may be same-cycle)
//   pc           current fetch PC
//   dpc4, inst   IF/ID register: PC+4 and instruction of the word in decode
//   fetch_stall  no fetched word available; decode must insert a bubble
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nostall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] da,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] inst,
  output logic        fetch_stall
);

  localparam logic [0:0] REQ  = 1'b0;  // request outstanding
  localparam logic [0:0] HOLD = 1'b1;  // word buffered, decode stalled

  logic [0:0]  state_q;
  logic [31:0] buf_q;
  logic [31:0] pc4;
  logic [31:0] npc;
  logic        avail;
  logic        advance;

  assign pc4         = pc + 32'd4;  // wraps modulo 2^32
  assign imem_addr   = {pc[31:2], 2'b00};
  assign imem_req    = (state_q == REQ);
  assign fetch_stall = (state_q == REQ) && !imem_ack;
  assign avail       = ((state_q == REQ) && imem_ack) || (state_q == HOLD);
  assign advance     = avail && nostall;

  always_comb begin
    npc = pc4;
    unique case (pcsource)
      2'b00: npc = pc4;
      2'b01: npc = bpc;
      2'b10: npc = da;
      2'b11: npc = jpc;
      default: npc = pc4;
    endcase
    npc[1:0] = 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      dpc4    <= 32'h0000_0000;
      inst    <= NOP_INST;
      state_q <= REQ;
      buf_q   <= 32'h0000_0000;
    end else if (advance) begin
      inst    <= (state_q == HOLD) ? buf_q : imem_rdata;
      dpc4    <= pc4;
      pc      <= npc;
      state_q <= REQ;
    end else if ((state_q == REQ) && imem_ack) begin
      // Word arrived but decode is stalled: park it and stop requesting.
      buf_q   <= imem_rdata;
      state_q <= HOLD;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        nostall;
  logic [1:0]  pcsource;
  logic [31:0] bpc, jpc, da;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] pc, dpc4, inst;
  logic        fetch_stall;

  int total = 0;
  int bad   = 0;

  // Memory model: returns addr | A000_0000 after `waits` wait cycles.
  int   waits  = 0;
  int   cnt    = 0;
  logic mem_on = 1'b1;

  assign imem_ack   = mem_on && imem_req && (cnt >= waits);
  assign imem_rdata = imem_addr | 32'hA000_0000;

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) cnt <= 0;
    else cnt <= cnt + 1;
  end

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .nostall    (nostall),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .jpc        (jpc),
    .da         (da),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .pc         (pc),
    .dpc4       (dpc4),
    .inst       (inst),
    .fetch_stall(fetch_stall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past a rising edge; inputs changed afterwards settle before checks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; nostall = 1'b1; pcsource = 2'b00;
    bpc = '0; jpc = '0; da = '0;

    // 1. Reset held 2 cycles, with zero-wait ack active throughout.
    tick(); tick();
    chk("rst_pc",   pc,        32'h0);
    chk("rst_inst", inst,      32'h0);
    chk("rst_dpc4", dpc4,      32'h0);
    chk("rst_req",  {31'b0, imem_req}, 32'h1);
    chk("rst_addr", imem_addr, 32'h0);
    rst = 1'b0;
    #1;
    chk("s2_stall0", {31'b0, fetch_stall}, 32'h0);

    // 2. Zero-wait streaming.
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("s2_addr",  imem_addr, 32'(4 * i));
      chk("s2_inst",  inst,      32'hA000_0000 | 32'(4 * (i - 1)));
      chk("s2_dpc4",  dpc4,      32'(4 * i));
      chk("s2_stall", {31'b0, fetch_stall}, 32'h0);
    end

    // 3. Two wait cycles at pc=C.
    waits = 2;
    #1;
    chk("s3_stall_a", {31'b0, fetch_stall}, 32'h1);
    tick();
    chk("s3_stall_b", {31'b0, fetch_stall}, 32'h1);
    chk("s3_pc_b",    pc,   32'hC);
    chk("s3_inst_b",  inst, 32'hA000_0008);
    tick();
    chk("s3_stall_c", {31'b0, fetch_stall}, 32'h0);
    chk("s3_pc_c",    pc,        32'hC);
    chk("s3_addr_c",  imem_addr, 32'hC);
    tick();
    chk("s3_pc_d",    pc,   32'h10);
    chk("s3_inst_d",  inst, 32'hA000_000C);
    chk("s3_dpc4_d",  dpc4, 32'h10);
    waits = 0;

    // 4. Ack at pc=0x10 while decode stalls for 3 cycles.
    nostall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s4_req",  {31'b0, imem_req}, 32'h0);
      chk("s4_inst", inst, 32'hA000_000C);
      chk("s4_pc",   pc,   32'h10);
    end
    nostall = 1'b1;
    tick();
    chk("s4_inst_rel", inst, 32'hA000_0010);
    chk("s4_dpc4_rel", dpc4, 32'h14);
    chk("s4_pc_rel",   pc,   32'h14);
    chk("s4_req_rel",  {31'b0, imem_req}, 32'h1);

    // 5. Redirects with delay slot; targets forced word aligned.
    pcsource = 2'b01; bpc = 32'h40;
    tick();
    chk("s5_b_inst", inst, 32'hA000_0014);
    chk("s5_b_dpc4", dpc4, 32'h18);
    chk("s5_b_pc",   pc,   32'h40);
    pcsource = 2'b10; da = 32'h83;
    tick();
    chk("s5_jr_inst", inst, 32'hA000_0040);
    chk("s5_jr_pc",   pc,   32'h80);
    pcsource = 2'b11; jpc = 32'h100;
    tick();
    chk("s5_j_inst", inst, 32'hA000_0080);
    chk("s5_j_dpc4", dpc4, 32'h84);
    chk("s5_j_pc",   pc,   32'h100);
    // pc+4 wrap at the top of the address space.
    jpc = 32'hFFFF_FFFC;
    tick();
    chk("s5_top_pc", pc, 32'hFFFF_FFFC);
    pcsource = 2'b00;
    tick();
    chk("s5_wrap_pc",   pc,   32'h0);
    chk("s5_wrap_dpc4", dpc4, 32'h0);
    chk("s5_wrap_inst", inst, 32'hFFFF_FFFC);

    // 6. Redirect held during a wait: pcsource ignored until ack.
    mem_on = 1'b0; pcsource = 2'b01; bpc = 32'h40;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("s6_wait_pc",    pc,   32'h0);
      chk("s6_wait_inst",  inst, 32'hFFFF_FFFC);
      chk("s6_wait_stall", {31'b0, fetch_stall}, 32'h1);
    end
    mem_on = 1'b1;
    tick();
    chk("s6_inst", inst, 32'hA000_0000);
    chk("s6_dpc4", dpc4, 32'h4);
    chk("s6_pc",   pc,   32'h40);

    // Async reset mid-wait, between clock edges.
    mem_on = 1'b0; pcsource = 2'b00;
    tick();
    chk("s6_pre_pc", pc, 32'h40);
    rst = 1'b1;
    #1;
    chk("s6_arst_pc",   pc,   32'h0);
    chk("s6_arst_inst", inst, 32'h0);
    chk("s6_arst_dpc4", dpc4, 32'h0);
    chk("s6_arst_req",  {31'b0, imem_req}, 32'h1);
    tick();
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
